// File: rtl/dmem_slave.sv
// dmem_slave: RV32I data-memory responder with byte-lane merge,
// load extension, alignment checks and optional wait states.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   mem_addr_i   : byte address (upper bits wrap modulo the array)
//   mem_data_i   : right-aligned store data
//   mem_size_i   : funct3 size code (B/H/W/BU/HU)
//   mem_we_i     : store request
//   mem_re_i     : load request
//   rdata_o      : extended load data, valid with ack_o
//   ack_o        : one-cycle completion pulse
//   hold_o       : stall request to the pipeline
//   err_o        : misaligned/illegal flag, coincident with ack_o
module dmem_slave #(
    parameter int DEPTH_WORDS = 4096,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    input  logic [2:0]  mem_size_i,
    input  logic        mem_we_i,
    input  logic        mem_re_i,
    output logic [31:0] rdata_o,
    output logic        ack_o,
    output logic        hold_o,
    output logic        err_o
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam bit HAS_WAIT = (WAIT_STATES > 0);
    localparam logic [2:0] CNT_INIT =
        HAS_WAIT ? 3'(WAIT_STATES - 1) : 3'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [2:0]    r_cnt;
    logic [AW+1:0] r_addr;
    logic [31:0]   r_data;
    logic [2:0]    r_size;
    logic          r_we;
    logic          r_re;
    logic [31:0]   r_rdata;
    logic          r_err;
    logic [31:0]   r_mem [DEPTH_WORDS];

    logic          w_in_wait;
    logic          w_accept;
    logic          w_enter_resp;
    logic          w_commit;
    logic [AW+1:0] w_addr;
    logic [31:0]   w_data;
    logic [2:0]    w_size;
    logic          w_we;
    logic          w_re;
    logic [AW-1:0] w_idx;
    logic [1:0]    w_lane;
    logic [31:0]   w_word;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic          w_sz_b;
    logic          w_sz_h;
    logic          w_sz_w;
    logic          w_illegal;
    logic          w_misalign;
    logic          w_bad;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata;
    logic [31:0]   w_ext;
    logic [31:0]   w_load_val;
    logic          w_unused;

    assign w_unused = &{1'b0, mem_addr_i[31:AW+2]};

    assign w_in_wait = (r_state == ST_WAIT);
    assign w_accept  = !w_in_wait && (mem_we_i || mem_re_i);

    // Without wait states the access completes on the accept edge,
    // so the live inputs drive the array; otherwise the captured copy.
    assign w_addr = w_in_wait ? r_addr : mem_addr_i[AW+1:0];
    assign w_data = w_in_wait ? r_data : mem_data_i;
    assign w_size = w_in_wait ? r_size : mem_size_i;
    assign w_we   = w_in_wait ? r_we   : mem_we_i;
    assign w_re   = w_in_wait ? r_re   : mem_re_i;

    assign w_enter_resp = (w_in_wait && r_cnt == 3'd0)
                       || (w_accept && !HAS_WAIT);
    assign w_commit = w_enter_resp && rst_n;

    assign w_idx  = w_addr[AW+1:2];
    assign w_lane = w_addr[1:0];
    assign w_word = r_mem[w_idx];
    assign w_byte = w_word[{w_lane, 3'b000} +: 8];
    assign w_half = w_lane[1] ? w_word[31:16] : w_word[15:0];

    assign w_sz_b = (w_size[1:0] == 2'b00);
    assign w_sz_h = (w_size[1:0] == 2'b01);
    assign w_sz_w = (w_size == 3'b010);

    // Unsigned variants only exist for loads.
    assign w_illegal = (w_size == 3'b011)
                    || (w_size[2] && w_size[1])
                    || (w_we && w_re)
                    || (w_we && w_size[2]);
    assign w_misalign = (w_sz_h && w_lane[0])
                     || (w_sz_w && w_lane != 2'd0);
    assign w_bad = w_illegal || w_misalign;

    always_comb begin
        w_be    = 4'b0000;
        w_wdata = 32'd0;
        w_ext   = 32'd0;
        unique case (1'b1)
            w_sz_b: begin
                w_be    = 4'b0001 << w_lane;
                w_wdata = {4{w_data[7:0]}};
                w_ext   = {{24{w_byte[7] & ~w_size[2]}}, w_byte};
            end
            w_sz_h: begin
                w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{w_data[15:0]}};
                w_ext   = {{16{w_half[15] & ~w_size[2]}}, w_half};
            end
            w_sz_w: begin
                w_be    = 4'b1111;
                w_wdata = w_data;
                w_ext   = w_word;
            end
            default: begin
            end
        endcase
    end

    assign w_load_val = (w_re && !w_bad) ? w_ext : 32'd0;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE, ST_RESP: begin
                if (w_accept) begin
                    w_state_nxt = HAS_WAIT ? ST_WAIT : ST_RESP;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (r_cnt == 3'd0) begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
            r_addr  <= '0;
            r_data  <= 32'd0;
            r_size  <= 3'd0;
            r_we    <= 1'b0;
            r_re    <= 1'b0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_addr <= mem_addr_i[AW+1:0];
                r_data <= mem_data_i;
                r_size <= mem_size_i;
                r_we   <= mem_we_i;
                r_re   <= mem_re_i;
                r_cnt  <= CNT_INIT;
            end else if (w_in_wait && r_cnt != 3'd0) begin
                r_cnt <= r_cnt - 3'd1;
            end
            if (w_enter_resp) begin
                r_rdata <= w_load_val;
                r_err   <= w_bad;
            end
        end
    end

    // Array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_commit && w_we && !w_bad) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
    end

    assign ack_o   = (r_state == ST_RESP);
    assign err_o   = (r_state == ST_RESP) && r_err;
    assign rdata_o = r_rdata;
    assign hold_o  = rst_n && (w_in_wait || (w_accept && HAS_WAIT));

endmodule

// File: doc/dmem_slave.md
# dmem_slave

Data-memory responder for the RV32I pipeline: the slave end of the execute stage's load/store port (address, data, size, write-enable, read-enable). It owns the data RAM array and performs byte-lane store merging, load sign/zero extension and alignment checking. A configurable wait-state counter with a hold output lets the pipeline model slow memory.

## Interface
- `DEPTH_WORDS`, 4096: number of 32-bit words; power of two, minimum 16.
- `WAIT_STATES`, 0: extra cycles per access, range 0..7.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `mem_addr_i`  in  32  byte address.
- `mem_data_i`  in  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
- `mem_size_i`  in  3  funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `mem_we_i`  in  1  store request.
- `mem_re_i`  in  1  load request.
- `rdata_o`  out  32  extended load data; valid while `ack_o`=1 for a load.
- `ack_o`  out  1  one-cycle completion pulse for every accepted request.
- `hold_o`  out  1  stall request to the pipeline control.
- `err_o`  out  1  one-cycle pulse, coincident with `ack_o`, for a misaligned or illegal request.

## Operation
- **FSM states:** IDLE, WAIT, RESP.
- **Acceptance:** a request is accepted at the rising edge when the state is IDLE or RESP and `mem_we_i` or `mem_re_i` is 1. Requests present in WAIT are ignored.
- **Capture:** address, data, size and type are registered at acceptance.
- **Transitions:**
  - IDLE/RESP to WAIT on accept if `WAIT_STATES`>0, with counter loaded to `WAIT_STATES`-1.
  - IDLE/RESP to RESP on accept if `WAIT_STATES`=0.
  - WAIT to RESP when counter=0; otherwise decrement.
  - RESP to IDLE when there is no new request.
- **Word index:** `addr[log2(DEPTH_WORDS)+1:2]`. Upper address bits are ignored, so addresses wrap modulo the array size.
- **Stores commit on the edge entering RESP:**
  - SB writes lane `addr[1:0]` with `data[7:0]`.
  - SH writes lanes `{addr[1],0}` and `{addr[1],1}` with `data[15:0]`.
  - SW writes all four lanes.
  - Unwritten lanes keep their old value.
- **Loads** read the array on the edge entering RESP, so a load accepted after a store observes the stored value.
  - B/BU take the lane at `addr[1:0]`; H/HU take the halfword at `addr[1]`.
  - B and H sign-extend; BU and HU zero-extend.
- **Misaligned requests:** H/HU/SH with `addr[0]`=1; W/SW with `addr[1:0]`≠0.
  - No array write; `rdata_o`=0; `err_o`=1 in RESP.
- **Illegal requests:**
  - Size codes 011, 110 and 111.
  - BU/HU codes with `mem_we_i`.
  - `mem_we_i` and `mem_re_i` both 1.
  - Treated as misaligned: no write, `rdata_o`=0, `err_o`=1.
- **Array contents** are not reset; simulation initial value is 0.

## Timing
- **Reset values:** state IDLE, counter 0, `rdata_o`=0, `ack_o`=0, `err_o`=0, `hold_o`=0. Deassertion is honoured on the next edge.
- **Latency:** a request accepted at the end of cycle N gives `ack_o`=1 in cycle N+1+`WAIT_STATES`.
- **`rdata_o`/`err_o`:** registered; held at the last value outside RESP. `rdata_o` is 0 after a store.
- **`hold_o`:**
  - Combinational: 1 when state is WAIT, or when a request is being accepted and `WAIT_STATES`>0.
  - 0 in RESP unless a new request with `WAIT_STATES`>0 is being accepted.
  - 0 in IDLE when there is no request.
- **Back-to-back:** a request present in the RESP cycle is accepted. With `WAIT_STATES`=0, one access per cycle is sustained with `ack_o` continuously 1.
- **Reset mid-operation:** `rst_n` low in WAIT or RESP aborts the access.
  - A store not yet committed is lost.
  - An already committed store is retained.
  - Outputs go to reset values immediately.

## Test plan
1. **Word round-trip:** `WAIT_STATES`=0; SW `0x0000_0010` data `0xDEAD_BEEF`, then LW `0x10` -> `ack_o` on both cycles; `rdata_o`=`0xDEADBEEF` in the second ack cycle; `hold_o` never 1.
2. **Byte/half merge and extension:**
   - Word 0 holds `0x1122_3344`; SB addr 1 data `0xFF` -> word reads `0x1122_FF44`.
   - LB addr 1 -> `0xFFFF_FFFF`; LBU addr 1 -> `0x0000_00FF`.
   - SH addr 2 data `0x8001`, then LH addr 2 -> `0xFFFF_8001`; LHU -> `0x0000_8001`.
3. **Wait states:** `WAIT_STATES`=3; LW accepted cycle 10 -> `hold_o`=1 cycles 10–13, `ack_o` only in cycle 14; a request presented in cycle 12 is not accepted.
4. **Misaligned and illegal:**
   - SW addr `0x6` data `0xAAAA_AAAA` -> `err_o`=1 with ack, words 0/1 unchanged.
   - LH addr 3 -> `err_o`=1, `rdata_o`=0.
   - Size 011 -> `err_o`=1.
5. **Wrap-around:** `DEPTH_WORDS`=16; SW addr `0x40` data `0x5` -> LW addr `0x0` returns `0x5`.
6. **Reset mid-access:** `WAIT_STATES`=2; SW accepted, `rst_n` pulsed low in the first WAIT cycle -> `ack_o`/`hold_o` immediately 0; a subsequent LW of that address returns the pre-store value.
